// File: rtl/left_shift_sequencer_if.sv
// Handshake and data bundle for left_shift_sequencer.
// master drives requests (start/in/amount/mode); slave returns status and result.
interface left_shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [AMT_W-1:0] amount;
  logic             mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             ovf;

  modport master (output start, in, amount, mode, input busy, done, out, ovf);
  modport slave  (input start, in, amount, mode, output busy, done, out, ovf);
endinterface

// File: rtl/left_shift_sequencer.sv
// Multi-cycle left shifter (one bit per clock) with start/busy/done handshake.
// Build macro LSHIFT_ROTATE_EN enables rotate-left on mode=1; otherwise mode is ignored.
//
// state | meaning
// IDLE  | waiting for start; operand/amount/mode captured on start
// SHIFT | one bit per clock; result and ovf published when count reaches 1
// DONE  | one-cycle done pulse, busy still high; returns to IDLE
module left_shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  left_shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;

  logic             rot;
  logic [WIDTH-1:0] sr_shift;
  logic             ovf_step;

`ifdef LSHIFT_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rot_q <= 1'b0;
    else if (state_q == IDLE && bus.start)
      rot_q <= bus.mode;
  end

  assign rot = rot_q;
`else
  logic unused_mode;

  assign unused_mode = bus.mode;
  assign rot         = 1'b0;
`endif

  // Rotate feeds the MSB back in; logical fills with zero and tracks sign changes.
  assign sr_shift = {sr_q[WIDTH-2:0], rot & sr_q[WIDTH-1]};
  assign ovf_step = ovf_acc_q | (~rot & (sr_q[WIDTH-1] ^ sr_q[WIDTH-2]));

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d      = bus.in;
          cnt_d     = bus.amount;
          ovf_acc_d = 1'b0;
          if (bus.amount == '0) begin
            out_d   = bus.in;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sr_d      = sr_shift;
        cnt_d     = cnt_q - 1'b1;
        ovf_acc_d = ovf_step;
        if (cnt_q == AMT_W'(1)) begin
          out_d   = sr_shift;
          ovf_d   = ovf_step;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_left_shift_sequencer.sv
// Directed self-checking bench for left_shift_sequencer (WIDTH=16, AMT_W=5).
// Expectations follow the LSHIFT_ROTATE_EN setting of the build.
module tb_left_shift_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  left_shift_sequencer_if #(.WIDTH(16), .AMT_W(5)) bus ();

  left_shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, scrambles inputs after capture, waits for done.
  task automatic run_op(input logic [15:0] a, input logic [4:0] n, input logic m,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    bus.in     = a;
    bus.amount = n;
    bus.mode   = m;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.in     = ~a;
    bus.amount = ~n;
    bus.mode   = ~m;
    lat        = 0;
    busy_cnt   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
    end
    if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  int lat, bc, dones;
  logic rot_en;

  initial begin
    checks     = 0;
    errors     = 0;
`ifdef LSHIFT_ROTATE_EN
    rot_en     = 1'b1;
`else
    rot_en     = 1'b0;
`endif
    bus.start  = 1'b0;
    bus.in     = '0;
    bus.amount = '0;
    bus.mode   = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out",  32'(bus.out),  32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);

    run_op(16'h00F1, 5'd4, 1'b0, lat, bc);
    check("t2_lat",  32'(lat),     32'd5);
    check("t2_busy", 32'(bc),      32'd5);
    check("t2_out",  32'(bus.out), 32'h0F10);
    check("t2_ovf",  32'(bus.ovf), 32'd0);
    @(negedge clk);
    check("t2_done_pulse", 32'(bus.done), 32'd0);
    check("t2_idle",       32'(bus.busy), 32'd0);

    run_op(16'h4000, 5'd1, 1'b0, lat, bc);
    check("t3a_lat", 32'(lat),     32'd2);
    check("t3a_out", 32'(bus.out), 32'h8000);
    check("t3a_ovf", 32'(bus.ovf), 32'd1);
    // started in the first IDLE cycle after the previous DONE
    run_op(16'hFFFF, 5'd31, 1'b0, lat, bc);
    check("t3b_lat", 32'(lat),     32'd32);
    check("t3b_out", 32'(bus.out), 32'h0000);
    check("t3b_ovf", 32'(bus.ovf), 32'd1);
    run_op(16'hC000, 5'd1, 1'b0, lat, bc);
    check("t3c_out", 32'(bus.out), 32'h8000);
    check("t3c_ovf", 32'(bus.ovf), 32'd0);

    run_op(16'h8001, 5'd1, 1'b1, lat, bc);
    check("t4a_out", 32'(bus.out), rot_en ? 32'h0003 : 32'h0002);
    check("t4a_ovf", 32'(bus.ovf), rot_en ? 32'd0 : 32'd1);
    run_op(16'h1234, 5'd20, 1'b1, lat, bc);
    check("t4b_out", 32'(bus.out), rot_en ? 32'h2341 : 32'h0000);
    check("t4b_ovf", 32'(bus.ovf), rot_en ? 32'd0 : 32'd1);
    run_op(16'h1234, 5'd16, 1'b1, lat, bc);
    check("t4c_out", 32'(bus.out), rot_en ? 32'h1234 : 32'h0000);

    run_op(16'hABCD, 5'd0, 1'b0, lat, bc);
    check("t5a_lat", 32'(lat),     32'd1);
    check("t5a_out", 32'(bus.out), 32'hABCD);
    check("t5a_ovf", 32'(bus.ovf), 32'd0);

    // start pulsed mid-operation and on the DONE cycle must be ignored
    @(negedge clk);
    bus.in = 16'h0003; bus.amount = 5'd3; bus.mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t5b_hold_out", 32'(bus.out), 32'hABCD);
        bus.in = 16'hFFFF; bus.amount = 5'd2; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        bus.start = 1'b1;
      end
    end
    bus.start = 1'b0;
    check("t5b_dones", 32'(dones),   32'd1);
    check("t5b_out",   32'(bus.out), 32'h0018);

    // reset aborts an operation in flight
    @(negedge clk);
    bus.in = 16'h0001; bus.amount = 5'd10; bus.mode = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_out",  32'(bus.out),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("t6_no_done", 32'(dones), 32'd0);
    run_op(16'h0001, 5'd10, 1'b0, lat, bc);
    check("t6_lat", 32'(lat),     32'd11);
    check("t6_out2", 32'(bus.out), 32'h0400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
